// File: rtl/tensor_core_pkg.sv
// Shared types for the tensor-core text path: decoder FSM states and the NUL byte.
package tensor_core_pkg;
    typedef enum logic [3:0] {
        IDLE, TOK_RD, TOK_WAIT, SEEK_RD, SEEK_CHK, COPY_RD, COPY_CHK, FIN, DONE
    } decoder_state;

    localparam int NUL = 0;
endpackage

// File: rtl/token_decoder.sv
// Token-ID stream to NUL-delimited text: walks the vocab RAM per token and copies
// the matching word into the output RAM, ending with a double NUL.
module token_decoder
    import tensor_core_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int VOCAB_BASE = 0,
    parameter int VOCAB_END  = 2**ADDR_WIDTH-1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] tok_addr,
    input  logic [DATA_WIDTH-1:0] tok_rdata,
    output logic [ADDR_WIDTH-1:0] voc_addr,
    input  logic [DATA_WIDTH-1:0] voc_rdata,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_wdata,
    output logic                  out_we
);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] VBASE   = ADDR_WIDTH'(VOCAB_BASE);
    localparam logic [ADDR_WIDTH-1:0] VEND    = ADDR_WIDTH'(VOCAB_END);
    localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);

    decoder_state state, state_d;
    logic [ADDR_WIDTH-1:0] tok_ptr, tok_ptr_d, out_ptr, out_ptr_d, voc_ptr, voc_ptr_d;
    logic [ADDR_WIDTH-1:0] tok_addr_d, voc_addr_d, out_addr_d;
    logic [DATA_WIDTH-1:0] skip, skip_d, out_wdata_d;
    logic at_start, at_start_d, first, first_d, out_full, out_full_d;
    logic busy_d, done_d, err_d, out_we_d;
    logic voc_nul;

    assign voc_nul = (voc_rdata == DATA_WIDTH'(NUL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tok_ptr   <= '0;
            out_ptr   <= '0;
            voc_ptr   <= '0;
            skip      <= '0;
            at_start  <= 1'b0;
            first     <= 1'b0;
            out_full  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            tok_addr  <= '0;
            voc_addr  <= '0;
            out_addr  <= '0;
            out_wdata <= '0;
            out_we    <= 1'b0;
        end else begin
            state     <= state_d;
            tok_ptr   <= tok_ptr_d;
            out_ptr   <= out_ptr_d;
            voc_ptr   <= voc_ptr_d;
            skip      <= skip_d;
            at_start  <= at_start_d;
            first     <= first_d;
            out_full  <= out_full_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            tok_addr  <= tok_addr_d;
            voc_addr  <= voc_addr_d;
            out_addr  <= out_addr_d;
            out_wdata <= out_wdata_d;
            out_we    <= out_we_d;
        end
    end

    // Read addresses are loaded on entry to the *_RD state so the RAM samples
    // them during *_RD and the data is ready in the following check state.
    always_comb begin
        state_d     = state;
        tok_ptr_d   = tok_ptr;
        out_ptr_d   = out_ptr;
        voc_ptr_d   = voc_ptr;
        skip_d      = skip;
        at_start_d  = at_start;
        first_d     = first;
        out_full_d  = out_full;
        busy_d      = busy;
        done_d      = 1'b0;
        err_d       = err;
        tok_addr_d  = tok_addr;
        voc_addr_d  = voc_addr;
        out_addr_d  = out_addr;
        out_wdata_d = out_wdata;
        out_we_d    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    err_d      = 1'b0;
                    tok_ptr_d  = '0;
                    out_ptr_d  = '0;
                    out_full_d = 1'b0;
                    tok_addr_d = '0;
                    busy_d     = 1'b1;
                    state_d    = TOK_RD;
                end
            end
            TOK_RD: state_d = TOK_WAIT;
            TOK_WAIT: begin
                if (tok_rdata == DATA_WIDTH'(NUL)) begin
                    state_d = FIN;
                end else begin
                    voc_ptr_d  = VBASE;
                    voc_addr_d = VBASE;
                    skip_d     = tok_rdata - ONE;
                    at_start_d = 1'b1;
                    first_d    = 1'b1;
                    state_d    = (tok_rdata == ONE) ? COPY_RD : SEEK_RD;
                end
            end
            SEEK_RD: state_d = SEEK_CHK;
            SEEK_CHK: begin
                if ((voc_nul && at_start) || voc_ptr == VEND) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    at_start_d = voc_nul;
                    if (voc_nul) skip_d = skip - ONE;
                    voc_ptr_d  = voc_ptr + 1'b1;
                    voc_addr_d = voc_ptr + 1'b1;
                    state_d    = (voc_nul && skip == ONE) ? COPY_RD : SEEK_RD;
                end
            end
            COPY_RD: state_d = COPY_CHK;
            COPY_CHK: begin
                if ((voc_nul && first) || out_full) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    out_we_d    = 1'b1;
                    out_addr_d  = out_ptr;
                    out_wdata_d = voc_rdata;
                    out_ptr_d   = out_ptr + 1'b1;
                    if (out_ptr == PTR_MAX) out_full_d = 1'b1;
                    if (!voc_nul) begin
                        first_d = 1'b0;
                        if (voc_ptr == VEND) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            voc_ptr_d  = voc_ptr + 1'b1;
                            voc_addr_d = voc_ptr + 1'b1;
                            state_d    = COPY_RD;
                        end
                    end else if (tok_ptr == PTR_MAX) begin
                        // token stream ran off the end of the RAM without a 0
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        tok_ptr_d  = tok_ptr + 1'b1;
                        tok_addr_d = tok_ptr + 1'b1;
                        state_d    = TOK_RD;
                    end
                end
            end
            FIN: begin
                if (out_full) begin
                    err_d = 1'b1;
                end else begin
                    out_we_d    = 1'b1;
                    out_addr_d  = out_ptr;
                    out_wdata_d = DATA_WIDTH'(NUL);
                end
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_token_decoder.sv
// Scoreboard bench for token_decoder: RAM models, expected-write queue, done/err monitor.
module tb_token_decoder;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 2**AW;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic busy, done, err, out_we;
    logic [AW-1:0] tok_addr, voc_addr, out_addr;
    logic [DW-1:0] tok_rdata, voc_rdata, out_wdata;
    logic [DW-1:0] tok_mem [N];
    logic [DW-1:0] voc_mem [N];
    logic [DW-1:0] out_mem [N];

    int total = 0, bad = 0, done_cnt = 0, cyc = 0;
    bit sb_on = 1'b0;
    logic [AW+DW-1:0] wr_q [$];
    logic err_q [$];
    logic [DW-1:0] tq [$];
    logic [DW-1:0] eq [$];

    always #5 clk = ~clk;

    token_decoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .tok_addr(tok_addr), .tok_rdata(tok_rdata),
        .voc_addr(voc_addr), .voc_rdata(voc_rdata),
        .out_addr(out_addr), .out_wdata(out_wdata), .out_we(out_we)
    );

    always @(posedge clk) begin
        tok_rdata <= tok_mem[tok_addr];
        voc_rdata <= voc_mem[voc_addr];
        if (out_we) out_mem[out_addr] <= out_wdata;
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every write and every done is compared against the queues
    always @(negedge clk) begin
        if (rst_n && sb_on && out_we) begin
            if (wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_write: got addr %0h data %0h expected no write", out_addr, out_wdata);
            end else begin
                check("write", {out_addr, out_wdata}, wr_q.pop_front());
            end
        end
        if (rst_n && done) begin
            done_cnt++;
            if (sb_on && err_q.size() > 0) check("err_at_done", err, err_q.pop_front());
        end
    end

    task automatic load_tokens();
        for (int i = 0; i < N; i++) tok_mem[i] = (i < tq.size()) ? tq[i] : '0;
    endtask

    task automatic run_case(input string nm, input logic exp_err, input int exp_lat, input bit dup_start);
        int t0;
        load_tokens();
        wr_q.delete();
        err_q.delete();
        for (int i = 0; i < eq.size(); i++) wr_q.push_back({AW'(i), eq[i]});
        err_q.push_back(exp_err);
        done_cnt = 0;
        sb_on = 1'b1;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        do begin
            @(negedge clk);
            start = dup_start && (cyc - t0 == 3);
        end while (!done && cyc - t0 < 400);
        start = 1'b0;
        check({nm, "_done_seen"}, done, 1);
        if (exp_lat > 0) check({nm, "_latency"}, cyc - t0, exp_lat);
        repeat (3) @(negedge clk);
        check({nm, "_done_count"}, done_cnt, 1);
        check({nm, "_writes_left"}, wr_q.size(), 0);
        check({nm, "_busy_idle"}, busy, 0);
        for (int i = 0; i < eq.size() && i < N; i++) check({nm, "_mem"}, out_mem[i], eq[i]);
        sb_on = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) voc_mem[i] = '0;
        voc_mem[0] = 8'h68; voc_mem[1] = 8'h69; voc_mem[2] = 8'h00;
        voc_mem[3] = 8'h79; voc_mem[4] = 8'h6F; voc_mem[5] = 8'h00;
        voc_mem[6] = 8'h61; voc_mem[7] = 8'h62; voc_mem[8] = 8'h63;
        voc_mem[9] = 8'h00; voc_mem[10] = 8'h00;
        tq = '{8'h00};
        load_tokens();

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_we", out_we, 0);
        check("rst_addrs", {tok_addr, voc_addr, out_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        tq = '{8'h02, 8'h01, 8'h00};
        eq = '{8'h79, 8'h6F, 8'h00, 8'h68, 8'h69, 8'h00, 8'h00};
        run_case("basic", 1'b0, 27, 1'b0);

        tq = '{8'h00};
        eq = '{8'h00};
        run_case("empty", 1'b0, 5, 1'b0);

        tq = '{8'h04, 8'h00};
        eq = '{};
        run_case("oor", 1'b1, 0, 1'b0);

        tq = '{8'h03, 8'h03, 8'h00};
        eq = '{8'h61, 8'h62, 8'h63, 8'h00, 8'h61, 8'h62, 8'h63, 8'h00, 8'h00};
        run_case("lastword", 1'b0, 49, 1'b0);

        tq = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h00};
        eq = '{};
        for (int k = 0; k < 4; k++) begin
            eq.push_back(8'h61); eq.push_back(8'h62); eq.push_back(8'h63); eq.push_back(8'h00);
        end
        run_case("overflow", 1'b1, 0, 1'b0);

        // abort mid-copy, then restart with a second start while busy
        tq = '{8'h03, 8'h03, 8'h00};
        load_tokens();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && !out_we; i++) @(negedge clk);
        check("abort_reached_copy", out_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_we", out_we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tq = '{8'h02, 8'h01, 8'h00};
        eq = '{8'h79, 8'h6F, 8'h00, 8'h68, 8'h69, 8'h00, 8'h00};
        run_case("restart", 1'b0, 27, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
